ram_refresh_arbiter: RTL and testbench
======================================

# ram_refresh_arbiter

Arbitrates the expansion SRAM between the Z80 (through the bank-mapping decode) and a secondary byte-wide requester, such as a RAM-disk or DMA port. The CPU always has priority. Its SRAM controls pass straight through whenever the arbiter is idle. Secondary accesses are slotted only into Z80 refresh cycles, when the CPU never uses expansion RAM. The block sits between the mapping CPLD logic and the SRAM pins.

## Interface
- `ADR_W`, default 19: SRAM address width (512K).
- `WAIT_W`, default 8: starvation counter width.
- `MAX_WAIT`, default 200: cycles a pending request may wait before `dma_starved` asserts.
- `clk` in 1: CPC 4 MHz clock, sole clock.
- `reset` in 1: synchronous, active-high.
- `mreq_b`, `rfsh_b`, `wr_b` in 1 each: Z80 bus strobes, active low.
- `cpu_ramcs_b`, `cpu_oe_b` in 1 each: CPU-side SRAM chip select and output enable from the mapping logic.
- `cpu_adr` in ADR_W: CPU-side SRAM address (bank bits plus A13..A0).
- `dma_req` in 1: level request, held until `dma_ack`.
- `dma_we` in 1: 1 = write, 0 = read; stable while `dma_req` is high.
- `dma_adr` in ADR_W: requester address; stable while `dma_req` is high.
- `dma_wdata` in 8: write data; stable while `dma_req` is high.
- `dma_ack` out 1: one-cycle completion pulse.
- `dma_rdata` out 8: read data, valid from `dma_ack` until the next ack.
- `dma_starved` out 1: wait exceeded `MAX_WAIT`.
- `conflict` out 1: sticky; CPU cycle collided with a secondary access.
- `sram_cs_b`, `sram_oe_b`, `sram_we_b` out 1 each: SRAM controls.
- `sram_adr` out ADR_W: SRAM address.
- `sram_dq_out` out 8: SRAM write data.
- `sram_dq_oe` out 1: enables the block's drive of the SRAM data bus.
- `sram_dq_in` in 8: SRAM read data.

## Operation
- States are IDLE, SETUP, STROBE and DONE.
- **IDLE**
  - The SRAM pins mirror the CPU side combinationally: `sram_cs_b`=`cpu_ramcs_b`, `sram_oe_b`=`cpu_oe_b`, `sram_we_b`=`wr_b`, `sram_adr`=`cpu_adr`.
  - `sram_dq_oe`=0.
- **IDLE→SETUP**: taken at a rising edge when all of the following hold:
  - `dma_req`=1;
  - `rfsh_b`=0 and `mreq_b`=0 are both sampled low, i.e. a refresh slot;
  - `dma_ack` is not asserted in the current cycle.
- **SETUP**
  - `sram_adr`=`dma_adr`, `sram_cs_b`=0, `sram_oe_b`=`dma_we`, `sram_we_b`=1.
  - `sram_dq_oe`=`dma_we`, `sram_dq_out`=`dma_wdata`.
  - Moves to STROBE after one cycle.
- **STROBE**
  - Drives as SETUP, except `sram_we_b`=!`dma_we`.
  - At the exiting edge, a read captures `sram_dq_in` into `dma_rdata`.
  - Moves to DONE.
- **DONE**
  - `sram_cs_b`=1 and `sram_we_b`=1.
  - `sram_dq_oe` is held for this cycle to provide write hold time.
  - `dma_ack`=1.
  - Returns to IDLE.
- **Conflict**: in SETUP or STROBE, `mreq_b`=0 with `rfsh_b`=1 means the CPU has started a real memory cycle.
  - The access aborts and the state goes to IDLE at that edge. No ack is issued; `dma_rdata` is unchanged.
  - `conflict` is set to 1 and stays set until `reset`.
  - The request stays pending and retries in a later slot.
- **Wait counter**
  - Counts clocks while `dma_req`=1 and the state is IDLE; saturates at all-ones.
  - Clears on the transition to SETUP or when `dma_req`=0.
  - `dma_starved` = (count ≥ `MAX_WAIT`), registered.
- A `dma_req` that drops before grant is abandoned silently and the counter clears.

## Timing
- **Reset** (synchronous, dominant over every other event):
  - state = IDLE;
  - `dma_ack`=0, `dma_rdata`=0x00, `dma_starved`=0, `conflict`=0, counter = 0;
  - SRAM pins in IDLE passthrough, with `sram_dq_oe`=0.
- **Reset mid-access**: returns to IDLE at that edge; no ack is issued.
- **Latency**: `dma_ack` is asserted 3 cycles after the granting edge (SETUP, STROBE, then DONE).
- **Throughput**: at most one secondary access per refresh slot, because DONE blocks re-grant for one cycle.
- **Simultaneous conflict and STROBE exit**: the conflict wins. The state goes to IDLE and no data is captured.
- **Slot length**: a normal Z80 refresh slot (at least 2 clocks low) covers SETUP and STROBE. DONE may overlap the following M1 T1, since CS is already released.

## Structure
- Package `ram_arb_pkg` holds:
  - the state enum (IDLE, SETUP, STROBE, DONE);
  - the defaults `ADR_W` and `WAIT_W`;
  - a localparam for the DONE write-hold cycle.
- One sub-module, `ram_arb_wait_ctr`: the saturating counter with clear and the registered threshold compare, parameterised by `WAIT_W` and `MAX_WAIT`.

## Test plan
- **Write slot**: set `dma_req`=1, `dma_we`=1, `dma_adr`=0x4A5C3, `dma_wdata`=0x5A, then pulse `rfsh_b`/`mreq_b` low for 2 clocks.
  - Expect `sram_adr`=0x4A5C3, `sram_we_b` low for exactly 1 cycle (STROBE), and `dma_ack` at grant+3.
- **Read**: with `sram_dq_in`=0xC3 at 0x00010, run a read request in one slot.
  - Expect `dma_rdata`=0xC3 with `dma_ack` high for 1 cycle, and `sram_oe_b` low in SETUP and STROBE.
- **Passthrough**: in IDLE, toggle `cpu_ramcs_b`, `cpu_oe_b`, `wr_b` and `cpu_adr`=0x7C000.
  - Expect the SRAM pins to equal the inputs in the same cycle, with `sram_dq_oe`=0.
- **Conflict**: drive `mreq_b`=0, `rfsh_b`=1 during SETUP.
  - Expect IDLE next cycle, no ack and `conflict`=1 sticky.
  - The retry in the next slot then acks normally.
- **Starvation**: set `MAX_WAIT`=200 and hold `dma_req` with no refresh slots.
  - Expect `dma_starved`=1 after 200 cycles, cleared on grant.
  - Assert `reset` mid-STROBE: all outputs return to their reset values and no ack is issued.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared state encoding and defaults for the refresh-slot SRAM arbiter
package ram_arb_pkg;
  localparam int DEF_ADR_W = 19;
  localparam int DEF_WAIT_W = 8;
  localparam logic DONE_HOLD_DQ = 1'b1;
  typedef enum logic [1:0] {IDLE, SETUP, STROBE, DONE} arb_state_e;
endpackage

// File: rtl/ram_arb_wait_ctr.sv
// ram_arb_wait_ctr: saturating wait counter with clear and registered starvation flag
module ram_arb_wait_ctr #(
  parameter int WAIT_W = 8,
  parameter int MAX_WAIT = 200
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic starved
);
  localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(MAX_WAIT);
  logic [WAIT_W-1:0] cnt, cnt_nxt;
  assign cnt_nxt = clr ? '0 : (inc && !(&cnt)) ? cnt + 1'b1 : cnt;
  always_ff @(posedge clk)
    if (reset) begin
      cnt <= '0;
      starved <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      starved <= cnt_nxt >= LIMIT;
    end
endmodule

// File: rtl/ram_refresh_arbiter.sv
// ram_refresh_arbiter: slots secondary SRAM accesses into Z80 refresh cycles, CPU passthrough otherwise
module ram_refresh_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADR_W = DEF_ADR_W,
  parameter int WAIT_W = DEF_WAIT_W,
  parameter int MAX_WAIT = 200
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mreq_b,
  input  logic             rfsh_b,
  input  logic             wr_b,
  input  logic             cpu_ramcs_b,
  input  logic             cpu_oe_b,
  input  logic [ADR_W-1:0] cpu_adr,
  input  logic             dma_req,
  input  logic             dma_we,
  input  logic [ADR_W-1:0] dma_adr,
  input  logic [7:0]       dma_wdata,
  output logic             dma_ack,
  output logic [7:0]       dma_rdata,
  output logic             dma_starved,
  output logic             conflict,
  output logic             sram_cs_b,
  output logic             sram_oe_b,
  output logic             sram_we_b,
  output logic [ADR_W-1:0] sram_adr,
  output logic [7:0]       sram_dq_out,
  output logic             sram_dq_oe,
  input  logic [7:0]       sram_dq_in
);
  arb_state_e state;
  logic idle, access, grant, clash;
  assign idle = state == IDLE;
  assign access = state == SETUP || state == STROBE;
  assign grant = idle && dma_req && !rfsh_b && !mreq_b && !dma_ack;
  // a non-refresh MREQ means the CPU owns the RAM again
  assign clash = access && !mreq_b && rfsh_b;
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      dma_ack <= 1'b0;
      dma_rdata <= '0;
      conflict <= 1'b0;
    end else begin
      dma_ack <= 1'b0;
      if (clash) begin
        state <= IDLE;
        conflict <= 1'b1;
      end else
        case (state)
          IDLE: state <= grant ? SETUP : IDLE;
          SETUP: state <= STROBE;
          STROBE: begin
            state <= DONE;
            dma_ack <= 1'b1;
            if (!dma_we) dma_rdata <= sram_dq_in;
          end
          default: state <= IDLE;
        endcase
    end
  assign sram_cs_b = idle ? cpu_ramcs_b : !access;
  assign sram_oe_b = idle ? cpu_oe_b : access ? dma_we : 1'b1;
  assign sram_we_b = idle ? wr_b : state == STROBE ? !dma_we : 1'b1;
  assign sram_adr = idle ? cpu_adr : dma_adr;
  assign sram_dq_out = dma_wdata;
  assign sram_dq_oe = access ? dma_we : state == DONE ? DONE_HOLD_DQ & dma_we : 1'b0;
  ram_arb_wait_ctr #(.WAIT_W(WAIT_W), .MAX_WAIT(MAX_WAIT)) u_wait_ctr (
    .clk(clk),
    .reset(reset),
    .clr(grant || !dma_req),
    .inc(dma_req && idle),
    .starved(dma_starved)
  );
endmodule

// File: tb/tb_ram_refresh_arbiter.sv
// tb_ram_refresh_arbiter: directed vectors with hand-computed expectations
module tb_ram_refresh_arbiter;
  logic clk = 1'b0, reset, mreq_b, rfsh_b, wr_b, cpu_ramcs_b, cpu_oe_b;
  logic [18:0] cpu_adr, dma_adr, sram_adr;
  logic dma_req, dma_we, dma_ack, dma_starved, conflict;
  logic [7:0] dma_wdata, dma_rdata, sram_dq_out, sram_dq_in;
  logic sram_cs_b, sram_oe_b, sram_we_b, sram_dq_oe;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  ram_refresh_arbiter #(.ADR_W(19), .WAIT_W(8), .MAX_WAIT(200)) dut (
    .clk(clk), .reset(reset), .mreq_b(mreq_b), .rfsh_b(rfsh_b), .wr_b(wr_b),
    .cpu_ramcs_b(cpu_ramcs_b), .cpu_oe_b(cpu_oe_b), .cpu_adr(cpu_adr),
    .dma_req(dma_req), .dma_we(dma_we), .dma_adr(dma_adr), .dma_wdata(dma_wdata),
    .dma_ack(dma_ack), .dma_rdata(dma_rdata), .dma_starved(dma_starved), .conflict(conflict),
    .sram_cs_b(sram_cs_b), .sram_oe_b(sram_oe_b), .sram_we_b(sram_we_b), .sram_adr(sram_adr),
    .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe), .sram_dq_in(sram_dq_in)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic slot(input logic on);
    mreq_b = !on;
    rfsh_b = !on;
  endtask
  initial begin
    reset = 1'b1; mreq_b = 1'b1; rfsh_b = 1'b1; wr_b = 1'b1; cpu_ramcs_b = 1'b1; cpu_oe_b = 1'b1;
    cpu_adr = '0; dma_req = 1'b0; dma_we = 1'b0; dma_adr = '0; dma_wdata = '0; sram_dq_in = '0;
    step(); step();
    reset = 1'b0;
    chk("rst_ack", 32'(dma_ack), 0);
    chk("rst_rdata", 32'(dma_rdata), 0);
    chk("rst_starved", 32'(dma_starved), 0);
    chk("rst_conflict", 32'(conflict), 0);
    chk("rst_dq_oe", 32'(sram_dq_oe), 0);
    chk("rst_cs", 32'(sram_cs_b), 1);
    // write slot
    dma_req = 1'b1; dma_we = 1'b1; dma_adr = 19'h4A5C3; dma_wdata = 8'h5A; slot(1);
    step();
    chk("wr_setup_adr", 32'(sram_adr), 'h4A5C3);
    chk("wr_setup_cs", 32'(sram_cs_b), 0);
    chk("wr_setup_we", 32'(sram_we_b), 1);
    chk("wr_setup_dqoe", 32'(sram_dq_oe), 1);
    chk("wr_setup_dq", 32'(sram_dq_out), 'h5A);
    chk("wr_setup_ack", 32'(dma_ack), 0);
    step();
    chk("wr_strobe_we", 32'(sram_we_b), 0);
    chk("wr_strobe_ack", 32'(dma_ack), 0);
    slot(0);
    step();
    chk("wr_done_ack", 32'(dma_ack), 1);
    chk("wr_done_we", 32'(sram_we_b), 1);
    chk("wr_done_cs", 32'(sram_cs_b), 1);
    chk("wr_done_dqoe", 32'(sram_dq_oe), 1);
    dma_req = 1'b0;
    step();
    chk("wr_ack_pulse", 32'(dma_ack), 0);
    chk("wr_idle_dqoe", 32'(sram_dq_oe), 0);
    // read slot
    dma_req = 1'b1; dma_we = 1'b0; dma_adr = 19'h00010; sram_dq_in = 8'hC3; slot(1);
    step();
    chk("rd_setup_oe", 32'(sram_oe_b), 0);
    chk("rd_setup_adr", 32'(sram_adr), 'h10);
    chk("rd_setup_dqoe", 32'(sram_dq_oe), 0);
    step();
    chk("rd_strobe_oe", 32'(sram_oe_b), 0);
    chk("rd_strobe_we", 32'(sram_we_b), 1);
    slot(0);
    step();
    chk("rd_done_ack", 32'(dma_ack), 1);
    chk("rd_done_data", 32'(dma_rdata), 'hC3);
    dma_req = 1'b0; sram_dq_in = 8'h11;
    step();
    chk("rd_ack_pulse", 32'(dma_ack), 0);
    chk("rd_data_hold", 32'(dma_rdata), 'hC3);
    // passthrough
    cpu_ramcs_b = 1'b0; cpu_oe_b = 1'b0; wr_b = 1'b1; cpu_adr = 19'h7C000;
    #1;
    chk("pt_cs0", 32'(sram_cs_b), 0);
    chk("pt_oe0", 32'(sram_oe_b), 0);
    chk("pt_we1", 32'(sram_we_b), 1);
    chk("pt_adr", 32'(sram_adr), 'h7C000);
    chk("pt_dqoe", 32'(sram_dq_oe), 0);
    cpu_ramcs_b = 1'b1; cpu_oe_b = 1'b1; wr_b = 1'b0;
    #1;
    chk("pt_cs1", 32'(sram_cs_b), 1);
    chk("pt_oe1", 32'(sram_oe_b), 1);
    chk("pt_we0", 32'(sram_we_b), 0);
    wr_b = 1'b1;
    step();
    // conflict during SETUP
    dma_req = 1'b1; dma_we = 1'b1; dma_adr = 19'h12345; dma_wdata = 8'hA5; slot(1);
    step();
    chk("cf_setup_adr", 32'(sram_adr), 'h12345);
    mreq_b = 1'b0; rfsh_b = 1'b1;
    step();
    chk("cf_flag", 32'(conflict), 1);
    chk("cf_no_ack", 32'(dma_ack), 0);
    chk("cf_idle_adr", 32'(sram_adr), 'h7C000);
    chk("cf_idle_we", 32'(sram_we_b), 1);
    mreq_b = 1'b1;
    step(); step();
    chk("cf_still_no_ack", 32'(dma_ack), 0);
    chk("cf_sticky", 32'(conflict), 1);
    slot(1);
    step();
    chk("cf_retry_setup", 32'(sram_cs_b), 0);
    step();
    slot(0);
    step();
    chk("cf_retry_ack", 32'(dma_ack), 1);
    chk("cf_sticky2", 32'(conflict), 1);
    dma_req = 1'b0;
    step();
    // starvation
    dma_req = 1'b1; dma_we = 1'b0; dma_adr = 19'h00020; sram_dq_in = 8'h77;
    repeat (199) step();
    chk("st_199", 32'(dma_starved), 0);
    step();
    chk("st_200", 32'(dma_starved), 1);
    repeat (100) step();
    chk("st_saturate", 32'(dma_starved), 1);
    slot(1);
    step();
    chk("st_grant_clr", 32'(dma_starved), 0);
    chk("st_setup_cs", 32'(sram_cs_b), 0);
    step();
    chk("st_strobe_oe", 32'(sram_oe_b), 0);
    slot(0); reset = 1'b1;
    step();
    chk("rs_ack", 32'(dma_ack), 0);
    chk("rs_rdata", 32'(dma_rdata), 0);
    chk("rs_conflict", 32'(conflict), 0);
    chk("rs_starved", 32'(dma_starved), 0);
    chk("rs_cs", 32'(sram_cs_b), 1);
    chk("rs_dqoe", 32'(sram_dq_oe), 0);
    reset = 1'b0; dma_req = 1'b0;
    step();
    chk("rs_no_late_ack", 32'(dma_ack), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
